// File: rtl/alu_serial.sv
// Hack ALU run SLICE bits per cycle, LSB first. The result appears N=WIDTH/SLICE edges after accept.
// Single op in flight: in_ready is low from accept until the cycle after the result handshake.
module alu_serial #(
  parameter int WIDTH = 16,
  parameter int SLICE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, out_q;
  logic [5:0]       ctrl_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q, zr_q, ng_q;

  logic [SLICE-1:0] xs, ys, r_s, os;
  logic [SLICE:0]   sum;
  logic             carry_d;
  logic [WIDTH-1:0] out_d;

  // x_q/y_q shift right each slice, so the active slice is always the low bits
  always_comb begin
    xs = ctrl_q[5] ? '0 : x_q[SLICE-1:0];
    if (ctrl_q[4]) xs = ~xs;
    ys = ctrl_q[3] ? '0 : y_q[SLICE-1:0];
    if (ctrl_q[2]) ys = ~ys;
    sum     = {1'b0, xs} + {1'b0, ys} + {{SLICE{1'b0}}, carry_q};
    r_s     = ctrl_q[1] ? sum[SLICE-1:0] : (xs & ys);
    os      = ctrl_q[0] ? ~r_s : r_s;
    carry_d = ctrl_q[1] ? sum[SLICE] : carry_q;
    out_d   = WIDTH'({os, out_q} >> SLICE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      ctrl_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            x_q        <= x;
            y_q        <= y;
            ctrl_q     <= ctrl;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          x_q     <= x_q >> SLICE;
          y_q     <= y_q >> SLICE;
          out_q   <= out_d;
          carry_q <= carry_d;
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            zr_q        <= (out_d == '0);
            ng_q        <= out_d[WIDTH-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign zr        = zr_q;
  assign ng        = ng_q;
endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: vector table through a scoreboard, plus backpressure, abort and SLICE=4 sequences.
module tb_alu_serial;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, in_valid4, out_ready4;
  logic [15:0] x, y;
  logic [5:0]  ctrl;
  logic        in_ready, out_valid, zr, ng;
  logic [15:0] dout;
  logic        in_ready4, out_valid4, zr4, ng4;
  logic [15:0] dout4;

  always #5 clk = ~clk;

  alu_serial #(.WIDTH(16), .SLICE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out(dout), .zr(zr), .ng(ng)
  );

  alu_serial #(.WIDTH(16), .SLICE(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .x(x), .y(y), .ctrl(ctrl), .out_valid(out_valid4), .out_ready(out_ready4),
    .out(dout4), .zr(zr4), .ng(ng4)
  );

  typedef struct {
    logic [5:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] o;
    logic        z;
    logic        n;
  } vec_t;

  typedef struct {
    logic [15:0] o;
    logic        z;
    logic        n;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[12];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_op(input vec_t v);
    int   w;
    exp_t e;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("in_ready_before_op", in_ready, 1);
    ctrl = v.c; x = v.a; y = v.b; in_valid = 1'b1;
    @(posedge clk);
    e.o = v.o; e.z = v.z; e.n = v.n;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    x = 16'($urandom); y = 16'($urandom); ctrl = 6'($urandom);
  endtask

  task automatic wait_result();
    int   lat;
    exp_t e;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 16);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: result with no expected entry");
    end else begin
      e = sb.pop_front();
      chk("out", dout, e.o);
      chk("zr", zr, e.z);
      chk("ng", ng, e.n);
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("out_valid_after_hs", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] held;
    int          lat;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    x = '0; y = '0; ctrl = '0;

    vecs[0]  = '{6'b000010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[1]  = '{6'b000000, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    vecs[2]  = '{6'b010011, 16'd5,    16'd5,    16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{6'b000010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[4]  = '{6'b111010, 16'h1234, 16'h5678, 16'hFFFF, 1'b0, 1'b1};
    vecs[5]  = '{6'b101010, 16'hABCD, 16'h1111, 16'h0000, 1'b1, 1'b0};
    vecs[6]  = '{6'b111111, 16'h0F0F, 16'hAAAA, 16'h0001, 1'b0, 1'b0};
    vecs[7]  = '{6'b001101, 16'h1234, 16'h9999, 16'hEDCB, 1'b0, 1'b1};
    vecs[8]  = '{6'b011111, 16'h00FF, 16'h4444, 16'h0100, 1'b0, 1'b0};
    vecs[9]  = '{6'b000111, 16'd3,    16'd10,   16'd7,    1'b0, 1'b0};
    vecs[10] = '{6'b010101, 16'hF000, 16'h000F, 16'hF00F, 1'b0, 1'b1};
    vecs[11] = '{6'b001111, 16'h0002, 16'h7777, 16'hFFFE, 1'b0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", dout, 16'h0000);
    chk("rst_zr", zr, 0);
    chk("rst_ng", ng, 0);
    chk("rst_in_ready4", in_ready4, 1);
    chk("rst_out_valid4", out_valid4, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      start_op(vecs[i]);
      wait_result();
      handshake();
    end

    // backpressure: result held while new operands are offered
    start_op('{6'b000010, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0});
    wait_result();
    held = dout;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        x = 16'h0001; y = 16'h0001; ctrl = 6'b000010; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      chk("bp_out_held", dout, held);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    handshake();
    repeat (20) @(negedge clk);
    chk("bp_no_new_op", out_valid, 0);
    chk("bp_out_kept", dout, 16'h3333);

    // abort with reset during slice 8
    start_op('{6'b000010, 16'h7FFF, 16'h7FFF, 16'hFFFE, 1'b0, 1'b1});
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out", dout, 16'h0000);
    chk("abort_zr", zr, 0);
    chk("abort_ng", ng, 0);
    repeat (20) @(negedge clk);
    chk("abort_no_result", out_valid, 0);
    start_op('{6'b000010, 16'd3, 16'd4, 16'd7, 1'b0, 1'b0});
    wait_result();
    handshake();

    // reset and in_valid at the same edge: no capture
    rst = 1'b1; in_valid = 1'b1; x = 16'h0005; y = 16'h0006; ctrl = 6'b000010;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_wins_out_valid", out_valid, 0);
    chk("rst_wins_in_ready", in_ready, 1);
    chk("rst_wins_out", dout, 16'h0000);

    // SLICE=4 instance
    ctrl = 6'b000010; x = 16'h1234; y = 16'h0FFF; in_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0; x = 16'hDEAD; y = 16'hBEEF;
    lat = 0;
    while (!out_valid4 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("s4_latency", lat, 4);
    chk("s4_out", dout4, 16'h2233);
    chk("s4_zr", zr4, 0);
    chk("s4_ng", ng4, 0);
    out_ready4 = 1'b1;
    @(negedge clk);
    out_ready4 = 1'b0;
    chk("s4_out_valid_after_hs", out_valid4, 0);
    chk("s4_in_ready_after_hs", in_ready4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
